// File: rtl/data_memory_responder_if.sv
// rtl/data_memory_responder_if.sv - MEM-stage data-memory bus and console TX stream bundle
interface data_memory_responder_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] out_mem_addr;
  logic [31:0] out_mem_data;
  logic        is_mem_write;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx_overflow;
  logic        misaligned;

  modport master (
    output mem_addr, out_mem_addr, out_mem_data, is_mem_write, tx_ready,
    input  mem_data, tx_valid, tx_data, tx_overflow, misaligned
  );

  modport slave (
    input  mem_addr, out_mem_addr, out_mem_data, is_mem_write, tx_ready,
    output mem_data, tx_valid, tx_data, tx_overflow, misaligned
  );
endinterface

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - word RAM with write bypass, cycle counter and console TX MMIO
module data_memory_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter string       INIT_FILE  = "",
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  data_memory_responder_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] OFF_CNT_LO = 2'd0;
  localparam logic [1:0] OFF_CNT_HI = 2'd1;
  localparam logic [1:0] OFF_TX     = 2'd2;
  localparam logic [1:0] OFF_STAT   = 2'd3;

  logic [31:0] mem_q [DEPTH];

  logic [63:0] cnt_q, cnt_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        mis_q, mis_d;

  logic                  rd_mmio, wr_mmio;
  logic [ADDR_WIDTH-1:0] rd_idx, wr_idx;
  logic [1:0]            wr_off;
  logic                  ram_we, tx_wr, stat_wr, tx_fire, bypass;
  logic [31:0]           rd_data;
  logic [1:0]            unused_rd_lsb;

  assign rd_mmio = (bus.mem_addr[31:4] == MMIO_BASE[31:4]);
  assign wr_mmio = (bus.out_mem_addr[31:4] == MMIO_BASE[31:4]);
  assign rd_idx  = bus.mem_addr[ADDR_WIDTH+1:2];
  assign wr_idx  = bus.out_mem_addr[ADDR_WIDTH+1:2];
  assign wr_off  = bus.out_mem_addr[3:2];
  assign unused_rd_lsb = bus.mem_addr[1:0];

  assign ram_we  = bus.is_mem_write && !wr_mmio;
  assign tx_wr   = bus.is_mem_write && wr_mmio && (wr_off == OFF_TX);
  assign stat_wr = bus.is_mem_write && wr_mmio && (wr_off == OFF_STAT);
  assign tx_fire = tx_valid_q && bus.tx_ready;
  assign bypass  = ram_we && !rd_mmio && (wr_idx == rd_idx);

  always_comb begin
    rd_data = 32'h0;
    if (rd_mmio) begin
      case (bus.mem_addr[3:2])
        OFF_CNT_LO: rd_data = cnt_q[31:0];
        OFF_CNT_HI: rd_data = cnt_q[63:32];
        OFF_TX:     rd_data = {24'h0, tx_data_q};
        OFF_STAT:   rd_data = {29'h0, mis_q, tx_ovf_q, tx_valid_q};
        default:    rd_data = 32'h0;
      endcase
    end else if (bypass) begin
      rd_data = bus.out_mem_data;
    end else begin
      rd_data = mem_q[rd_idx];
    end
  end

  assign bus.mem_data    = rd_data;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_overflow = tx_ovf_q;
  assign bus.misaligned  = mis_q;

  // Sticky flags: the write-1-to-clear is applied last so it beats any same-cycle set.
  always_comb begin
    cnt_d      = cnt_q + 64'd1;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_ovf_d   = tx_ovf_q;
    mis_d      = mis_q;
    if (tx_fire) begin
      tx_valid_d = 1'b0;
    end
    if (tx_wr) begin
      if (!tx_valid_q || bus.tx_ready) begin
        tx_data_d  = bus.out_mem_data[7:0];
        tx_valid_d = 1'b1;
      end else begin
        tx_ovf_d = 1'b1;
      end
    end
    if (bus.is_mem_write && (bus.out_mem_addr[1:0] != 2'b00)) begin
      mis_d = 1'b1;
    end
    if (stat_wr && bus.out_mem_data[1]) begin
      tx_ovf_d = 1'b0;
    end
    if (stat_wr && bus.out_mem_data[2]) begin
      mis_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 64'h0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h0;
      tx_ovf_q   <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_ovf_q   <= tx_ovf_d;
      mis_q      <= mis_d;
    end
  end

  // RAM has no reset; gating on rst_n drops a write presented while reset is held.
  always_ff @(posedge clk) begin
    if (ram_we && rst_n) begin
      mem_q[wr_idx] <= bus.out_mem_data;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - vector table plus TX scoreboard bench for data_memory_responder
module tb_data_memory_responder;

  localparam logic [31:0] B = 32'hFFFF_FF00;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [7:0] exp_tx[$];

  data_memory_responder_if bus();

  data_memory_responder #(
    .ADDR_WIDTH (12),
    .INIT_FILE  (""),
    .MMIO_BASE  (B)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; combinational reads settle 1ns later.
  task automatic drive(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [31:0] ra, input logic rdy);
    @(negedge clk);
    bus.is_mem_write = we;
    bus.out_mem_addr = wa;
    bus.out_mem_data = wd;
    bus.mem_addr     = ra;
    bus.tx_ready     = rdy;
    #1;
  endtask

  // TX consumer: sampled 1ns before the rising edge on which the transfer happens.
  always @(negedge clk) begin
    #4;
    if (rst_n && bus.tx_valid && bus.tx_ready) begin
      if (exp_tx.size() == 0) begin
        chk("tx_unexpected", {24'h0, bus.tx_data}, 32'hFFFF_FFFF);
      end else begin
        chk("tx_byte", {24'h0, bus.tx_data}, {24'h0, exp_tx.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.is_mem_write = 1'b0;
    bus.out_mem_addr = 32'h0;
    bus.out_mem_data = 32'h0;
    bus.mem_addr     = B;
    bus.tx_ready     = 1'b0;

    vecs[0]  = '{1'b1, 32'h84,   32'hCAFE_F00D, 32'h84,   32'hCAFE_F00D};
    vecs[1]  = '{1'b1, 32'h40,   32'hDEAD_BEEF, 32'h84,   32'hCAFE_F00D};
    vecs[2]  = '{1'b0, 32'h0,    32'h0,         32'h40,   32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 32'h0,    32'h0,         32'h42,   32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 32'h80,   32'h1234_5678, 32'h80,   32'h1234_5678};
    vecs[5]  = '{1'b1, 32'h80,   32'h1111_1111, 32'h84,   32'hCAFE_F00D};
    vecs[6]  = '{1'b0, 32'h0,    32'h0,         32'h80,   32'h1111_1111};
    vecs[7]  = '{1'b1, 32'h4040, 32'h0BAD_C0DE, 32'h40,   32'h0BAD_C0DE};
    vecs[8]  = '{1'b0, 32'h0,    32'h0,         32'h4040, 32'h0BAD_C0DE};
    vecs[9]  = '{1'b1, B+32'h4,  32'hFFFF_FFFF, B+32'h4,  32'h0};
    vecs[10] = '{1'b0, 32'h0,    32'h0,         B+32'hC,  32'h0};
    vecs[11] = '{1'b1, 32'h42,   32'h5555_AAAA, 32'h40,   32'h5555_AAAA};
    vecs[12] = '{1'b0, 32'h0,    32'h0,         B+32'hC,  32'h4};
    vecs[13] = '{1'b1, B+32'hC,  32'h4,         32'h40,   32'h5555_AAAA};
    vecs[14] = '{1'b0, 32'h0,    32'h0,         B+32'hC,  32'h0};
    vecs[15] = '{1'b0, 32'h0,    32'h0,         B+32'h8,  32'h0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
    chk("rst_overflow", {31'h0, bus.tx_overflow}, 32'h0);
    chk("rst_misaligned", {31'h0, bus.misaligned}, 32'h0);
    chk("rst_counter", bus.mem_data, 32'h0);

    // Counter: released at a falling edge, so k rising edges later it reads k.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("counter_5", bus.mem_data, 32'd5);
    repeat (10) @(negedge clk);
    #1;
    chk("counter_15", bus.mem_data, 32'd15);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr, 1'b0);
      chk($sformatf("vec%0d", i), bus.mem_data, vecs[i].exp);
    end

    // Single-entry TX buffer: fill, overflow, drain.
    drive(1'b1, B+32'h8, 32'h41, B+32'hC, 1'b0);
    exp_tx.push_back(8'h41);
    chk("tx_stat_pre", bus.mem_data, 32'h0);
    drive(1'b1, B+32'h8, 32'h42, B+32'h8, 1'b0);
    chk("tx_valid_fill", {31'h0, bus.tx_valid}, 32'h1);
    chk("tx_rd_data", bus.mem_data, 32'h41);
    drive(1'b0, 32'h0, 32'h0, B+32'hC, 1'b1);
    chk("tx_ovf_set", {31'h0, bus.tx_overflow}, 32'h1);
    chk("tx_data_held", {24'h0, bus.tx_data}, 32'h41);
    chk("tx_stat_full", bus.mem_data, 32'h3);
    drive(1'b0, 32'h0, 32'h0, B+32'hC, 1'b0);
    chk("tx_valid_drop", {31'h0, bus.tx_valid}, 32'h0);
    chk("tx_stat_ovf", bus.mem_data, 32'h2);

    // Sticky flags: set misaligned, clear both, then clear beats same-cycle set.
    drive(1'b1, 32'h203, 32'h77, B+32'hC, 1'b0);
    drive(1'b1, B+32'hC, 32'h6, B+32'hC, 1'b0);
    chk("flags_both", bus.mem_data, 32'h6);
    drive(1'b1, B+32'hD, 32'h4, B+32'hC, 1'b0);
    chk("flags_cleared", bus.mem_data, 32'h0);
    drive(1'b1, B+32'h8, 32'h43, B+32'hC, 1'b0);
    exp_tx.push_back(8'h43);
    chk("clear_wins", bus.mem_data, 32'h0);
    drive(1'b1, B+32'h8, 32'h44, B+32'h8, 1'b1);
    exp_tx.push_back(8'h44);
    chk("refill_old", bus.mem_data, 32'h43);
    drive(1'b0, 32'h0, 32'h0, B+32'hC, 1'b0);
    chk("refill_stat", bus.mem_data, 32'h1);
    chk("refill_data", {24'h0, bus.tx_data}, 32'h44);
    drive(1'b0, 32'h0, 32'h0, B+32'hC, 1'b1);
    drive(1'b0, 32'h0, 32'h0, B+32'hC, 1'b0);
    chk("drain_valid", {31'h0, bus.tx_valid}, 32'h0);

    // Low word rollover carries into the high word.
    drive(1'b0, 32'h0, 32'h0, B+32'h4, 1'b0);
    force dut.cnt_q = 64'h0000_0007_FFFF_FFFF;
    #1;
    chk("cnt_forced_hi", bus.mem_data, 32'h7);
    bus.mem_addr = B;
    #1;
    chk("cnt_forced_lo", bus.mem_data, 32'hFFFF_FFFF);
    release dut.cnt_q;
    @(negedge clk);
    #1;
    chk("cnt_wrap_lo", bus.mem_data, 32'h0);
    bus.mem_addr = B + 32'h4;
    #1;
    chk("cnt_carry_hi", bus.mem_data, 32'h8);

    // Async reset mid-cycle with a pending byte and a sticky flag.
    drive(1'b1, 32'h203, 32'h99, B+32'hC, 1'b0);
    drive(1'b1, B+32'h8, 32'h55, B+32'hC, 1'b0);
    exp_tx.push_back(8'h55);
    drive(1'b0, 32'h0, 32'h0, B+32'hC, 1'b0);
    chk("pre_rst_stat", bus.mem_data, 32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    exp_tx.delete();
    chk("arst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    chk("arst_stat", bus.mem_data, 32'h0);
    bus.mem_addr = B;
    #1;
    chk("arst_counter", bus.mem_data, 32'h0);
    drive(1'b1, 32'h40, 32'hFFFF_0000, B, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 32'h40, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("ram_kept", bus.mem_data, 32'h5555_AAAA);
    drive(1'b0, 32'h0, 32'h0, B, 1'b0);
    chk("cnt_after_rst", bus.mem_data, 32'h1);

    chk("tx_queue_empty", exp_tx.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
